// File: rtl/vj_scan_scheduler_if.sv
// ---------------------------------------------------------------------------
// vj_scan_scheduler_if
// Window-offer bus between the scan scheduler and the window-select /
// std-dev / vj_pipeline datapath.
//   img_index  : pyramid level of the offered window (4'd15 when idle)
//   row_index  : window top row within that level
//   col_index  : window left column within that level
//   win_valid  : window indices valid and offered
//   win_ready  : datapath accepts the offered window this cycle
// Modports: master = scheduler side, slave = datapath side.
// ---------------------------------------------------------------------------
interface vj_scan_scheduler_if;
  logic [3:0]  img_index;
  logic [31:0] row_index;
  logic [31:0] col_index;
  logic        win_valid;
  logic        win_ready;

  modport master (
    output img_index,
    output row_index,
    output col_index,
    output win_valid,
    input  win_ready
  );

  modport slave (
    input  img_index,
    input  row_index,
    input  col_index,
    input  win_valid,
    output win_ready
  );
endinterface

// File: rtl/vj_scan_scheduler.sv
// ---------------------------------------------------------------------------
// vj_scan_scheduler
// Sequencing controller for the Viola-Jones detection datapath. After a new
// frame is captured it waits INT_WAIT cycles for the integral images to
// settle, walks the scanning window over every pyramid level in raster
// order under a valid/ready handshake, waits DRAIN_CYCLES for the pipeline
// to empty, then pulses frame_done. Faces reported by the pipeline while a
// frame is in progress are counted (saturating at 16'hFFFF).
//
// Ports:
//   clock          : system clock
//   reset_n        : asynchronous active-low reset
//   laptop_img_rdy : 1-cycle pulse, new frame captured into level 0
//   face_in_valid  : 1-cycle pulse, one face detected by vj_pipeline
//   win            : window-offer bus (vj_scan_scheduler_if.master)
//   busy           : frame in progress (SETTLE, SCAN or DRAIN)
//   frame_done     : 1-cycle pulse, frame fully processed
//   face_count     : faces in current/last frame, saturating
//   img_dropped    : 1-cycle pulse, laptop_img_rdy ignored while busy
//
// Build option:
//   SCAN_STRIDE2_EN : when defined, rows and columns advance by 2 instead
//                     of 1 (only even positions are visited).
// ---------------------------------------------------------------------------
`ifndef PYRAMID_WIDTHS
`define PYRAMID_WIDTHS {32'd54, 32'd67, 32'd84, 32'd105, 32'd131, 32'd164, 32'd205, 32'd256, 32'd320}
`endif
`ifndef PYRAMID_HEIGHTS
`define PYRAMID_HEIGHTS {32'd40, 32'd50, 32'd63, 32'd79, 32'd98, 32'd123, 32'd154, 32'd192, 32'd240}
`endif

module vj_scan_scheduler #(
  parameter int                        LEVELS       = 9,
  parameter int                        WINDOW_SIZE  = 24,
  parameter logic [LEVELS-1:0][31:0]   WIDTHS       = `PYRAMID_WIDTHS,
  parameter logic [LEVELS-1:0][31:0]   HEIGHTS      = `PYRAMID_HEIGHTS,
  parameter int                        INT_WAIT     = 10,
  parameter int                        DRAIN_CYCLES = 8
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       laptop_img_rdy,
  input  logic                       face_in_valid,
  vj_scan_scheduler_if.master        win,
  output logic                       busy,
  output logic                       frame_done,
  output logic [15:0]                face_count,
  output logic                       img_dropped
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;
  localparam logic [1:0] ST_DRAIN  = 2'd3;

`ifdef SCAN_STRIDE2_EN
  localparam logic [31:0] STEP = 32'd2;
`else
  localparam logic [31:0] STEP = 32'd1;
`endif

  localparam logic [3:0]  NO_LEVEL   = 4'd15;
  localparam logic [3:0]  LAST_LEVEL = 4'(LEVELS - 1);
  localparam logic [31:0] SETTLE_END = 32'(INT_WAIT);
  localparam logic [31:0] DRAIN_END  = 32'(DRAIN_CYCLES);

  logic [1:0]  state;
  logic [31:0] cnt;
  logic [3:0]  img_q;
  logic [31:0] row_q;
  logic [31:0] col_q;
  logic        valid_q;
  logic [31:0] max_col;
  logic [31:0] max_row;
  logic        col_adv;
  logic        row_adv;

  assign win.img_index = img_q;
  assign win.row_index = row_q;
  assign win.col_index = col_q;
  assign win.win_valid = valid_q;

  // Last legal window origin of the current level. Outside SCAN img_q is
  // 15, which matches no level and leaves the limits at zero (unused then).
  always_comb begin
    max_col = 32'd0;
    max_row = 32'd0;
    for (int l = 0; l < LEVELS; l++) begin
      if (img_q == 4'(l)) begin
        max_col = WIDTHS[l]  - 32'(WINDOW_SIZE) - 32'd1;
        max_row = HEIGHTS[l] - 32'(WINDOW_SIZE) - 32'd1;
      end
    end
  end

  assign col_adv = (col_q + STEP) <= max_col;
  assign row_adv = (row_q + STEP) <= max_row;

  // Frame FSM. frame_done is raised on the edge where the drain counter
  // reaches DRAIN_CYCLES so the pulse coincides with that count; the FSM
  // leaves DRAIN one edge later, which drops busy as frame_done falls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      cnt         <= 32'd0;
      img_q       <= NO_LEVEL;
      row_q       <= 32'd0;
      col_q       <= 32'd0;
      valid_q     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      face_count  <= 16'd0;
      img_dropped <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      img_dropped <= (state != ST_IDLE) && laptop_img_rdy;

      if ((state != ST_IDLE) && face_in_valid && (face_count != 16'hFFFF)) begin
        face_count <= face_count + 16'd1;
      end

      case (state)
        ST_IDLE: begin
          if (laptop_img_rdy) begin
            state      <= ST_SETTLE;
            cnt        <= 32'd1;
            face_count <= 16'd0;
            busy       <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (cnt >= SETTLE_END) begin
            state   <= ST_SCAN;
            img_q   <= 4'd0;
            row_q   <= 32'd0;
            col_q   <= 32'd0;
            valid_q <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        ST_SCAN: begin
          if (valid_q && win.win_ready) begin
            if (col_adv) begin
              col_q <= col_q + STEP;
            end else if (row_adv) begin
              col_q <= 32'd0;
              row_q <= row_q + STEP;
            end else if (img_q != LAST_LEVEL) begin
              img_q <= img_q + 4'd1;
              row_q <= 32'd0;
              col_q <= 32'd0;
            end else begin
              state      <= ST_DRAIN;
              valid_q    <= 1'b0;
              img_q      <= NO_LEVEL;
              row_q      <= 32'd0;
              col_q      <= 32'd0;
              cnt        <= 32'd1;
              frame_done <= (DRAIN_END <= 32'd1);
            end
          end
        end
        default: begin
          if (cnt >= DRAIN_END) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            cnt        <= cnt + 32'd1;
            frame_done <= ((cnt + 32'd1) == DRAIN_END);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vj_scan_scheduler.sv
// ---------------------------------------------------------------------------
// tb_vj_scan_scheduler
// Directed bench for vj_scan_scheduler. dutA: two levels (26x26, 25x25);
// dutB: one level 29x27. Expected window sequences are written out by hand
// for both stride settings (SCAN_STRIDE2_EN).
// ---------------------------------------------------------------------------
module tb_vj_scan_scheduler;

  localparam int INT_WAIT     = 10;
  localparam int DRAIN_CYCLES = 8;

`ifdef SCAN_STRIDE2_EN
  localparam int NA = 2;
  localparam int NB = 6;
  int expA [NA][3] = '{'{0,0,0}, '{1,0,0}};
  int expB [NB][3] = '{'{0,0,0}, '{0,0,2}, '{0,0,4}, '{0,2,0}, '{0,2,2}, '{0,2,4}};
`else
  localparam int NA = 5;
  localparam int NB = 15;
  int expA [NA][3] = '{'{0,0,0}, '{0,0,1}, '{0,1,0}, '{0,1,1}, '{1,0,0}};
  int expB [NB][3] = '{'{0,0,0}, '{0,0,1}, '{0,0,2}, '{0,0,3}, '{0,0,4},
                       '{0,1,0}, '{0,1,1}, '{0,1,2}, '{0,1,3}, '{0,1,4},
                       '{0,2,0}, '{0,2,1}, '{0,2,2}, '{0,2,3}, '{0,2,4}};
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        laptopA = 1'b0, faceA = 1'b0, laptopB = 1'b0, faceB = 1'b0;
  logic        busyA, doneA, dropA, busyB, doneB, dropB;
  logic [15:0] countA, countB;

  int checks = 0;
  int errors = 0;

  vj_scan_scheduler_if busA ();
  vj_scan_scheduler_if busB ();

  always #5 clock = ~clock;

  vj_scan_scheduler #(
    .LEVELS(2), .WINDOW_SIZE(24),
    .WIDTHS({32'd25, 32'd26}), .HEIGHTS({32'd25, 32'd26}),
    .INT_WAIT(INT_WAIT), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dutA (
    .clock(clock), .reset_n(reset_n), .laptop_img_rdy(laptopA),
    .face_in_valid(faceA), .win(busA.master), .busy(busyA),
    .frame_done(doneA), .face_count(countA), .img_dropped(dropA)
  );

  vj_scan_scheduler #(
    .LEVELS(1), .WINDOW_SIZE(24),
    .WIDTHS({32'd29}), .HEIGHTS({32'd27}),
    .INT_WAIT(INT_WAIT), .DRAIN_CYCLES(DRAIN_CYCLES)
  ) dutB (
    .clock(clock), .reset_n(reset_n), .laptop_img_rdy(laptopB),
    .face_in_valid(faceB), .win(busB.master), .busy(busyB),
    .frame_done(doneB), .face_count(countB), .img_dropped(dropB)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkWin(input string tag, input logic [3:0] img,
                          input logic [31:0] row, input logic [31:0] col,
                          input int eImg, input int eRow, input int eCol);
    checkOutput({tag, "_img"}, 32'(img), eImg);
    checkOutput({tag, "_row"}, row, eRow);
    checkOutput({tag, "_col"}, col, eCol);
  endtask

  task automatic checkResetA(input string tag);
    checkWin(tag, busA.img_index, busA.row_index, busA.col_index, 15, 0, 0);
    checkOutput({tag, "_valid"}, 32'(busA.win_valid), 0);
    checkOutput({tag, "_busy"}, 32'(busyA), 0);
    checkOutput({tag, "_done"}, 32'(doneA), 0);
    checkOutput({tag, "_count"}, 32'(countA), 0);
    checkOutput({tag, "_dropped"}, 32'(dropA), 0);
  endtask

  task automatic waitValidA(input string tag);
    int n = 0;
    while (!busA.win_valid && n < 40) begin
      tick();
      n++;
    end
    checkOutput(tag, 32'(busA.win_valid), 1);
  endtask

  initial begin
    int expFaces;
    int accepted;
    logic holdPending;
    logic [3:0] hImg;
    logic [31:0] hRow, hCol;

    busA.win_ready = 1'b0;
    busB.win_ready = 1'b0;

    // Reset values
    reset_n = 1'b0;
    repeat (3) tick();
    checkResetA("reset");
    checkOutput("reset_b_valid", 32'(busB.win_valid), 0);
    checkOutput("reset_b_img", 32'(busB.img_index), 15);
    reset_n = 1'b1;
    tick();

    // Basic scan, settle latency, drain timing and face counting
    busA.win_ready = 1'b1;
    laptopA = 1'b1;
    tick();
    laptopA = 1'b0;
    checkOutput("settle_busy", 32'(busyA), 1);
    checkOutput("settle_novalid", 32'(busA.win_valid), 0);
    for (int i = 1; i <= INT_WAIT; i++) begin
      tick();
      checkOutput("first_win_latency", 32'(busA.win_valid), (i == INT_WAIT) ? 1 : 0);
    end
    expFaces = 0;
    for (int k = 0; k < NA; k++) begin
      checkWin("scan_seq", busA.img_index, busA.row_index, busA.col_index,
               expA[k][0], expA[k][1], expA[k][2]);
      checkOutput("scan_valid", 32'(busA.win_valid), 1);
      faceA = (k < 3);
      if (k < 3) expFaces++;
      tick();
    end
    faceA = 1'b0;
    checkOutput("drain_valid", 32'(busA.win_valid), 0);
    checkWin("drain_idx", busA.img_index, busA.row_index, busA.col_index, 15, 0, 0);
    checkOutput("drain_busy", 32'(busyA), 1);
    for (int d = 1; d <= DRAIN_CYCLES; d++) begin
      checkOutput("frame_done_timing", 32'(doneA), (d == DRAIN_CYCLES) ? 1 : 0);
      faceA = (d == DRAIN_CYCLES);
      tick();
    end
    faceA = 1'b0;
    expFaces++;
    checkOutput("done_single", 32'(doneA), 0);
    checkOutput("idle_busy", 32'(busyA), 0);
    checkOutput("face_count_final", 32'(countA), expFaces);
    faceA = 1'b1;
    tick();
    faceA = 1'b0;
    checkOutput("face_idle_ignored", 32'(countA), expFaces);

    // Stalled handshake, dropped frame request, count preserved
    laptopA = 1'b1;
    tick();
    laptopA = 1'b0;
    checkOutput("face_count_cleared", 32'(countA), 0);
    faceA = 1'b1;
    tick();
    faceA = 1'b0;
    checkOutput("face_settle_counted", 32'(countA), 1);
    waitValidA("stall_start");
    accepted = 0;
    holdPending = 1'b0;
    for (int c = 0; c < 40 && busA.win_valid; c++) begin
      if (holdPending) begin
        checkWin("hold", busA.img_index, busA.row_index, busA.col_index,
                 int'(hImg), int'(hRow), int'(hCol));
      end
      busA.win_ready = (c % 4 == 0) || (c % 4 == 3);
      if (busA.win_ready) begin
        if (accepted < NA) begin
          checkWin("stall_seq", busA.img_index, busA.row_index, busA.col_index,
                   expA[accepted][0], expA[accepted][1], expA[accepted][2]);
        end else begin
          checkOutput("extra_window", 32'(accepted), NA - 1);
        end
        accepted++;
        holdPending = 1'b0;
      end else begin
        hImg = busA.img_index;
        hRow = busA.row_index;
        hCol = busA.col_index;
        holdPending = 1'b1;
      end
      laptopA = (c == 1);
      tick();
      laptopA = 1'b0;
      if (c == 1) checkOutput("img_dropped_pulse", 32'(dropA), 1);
      if (c == 2) checkOutput("img_dropped_single", 32'(dropA), 0);
    end
    checkOutput("accept_count", 32'(accepted), NA);
    checkOutput("stall_end_valid", 32'(busA.win_valid), 0);
    for (int i = 0; i < DRAIN_CYCLES + 4 && !doneA; i++) tick();
    checkOutput("stall_done_seen", 32'(doneA), 1);
    checkOutput("count_not_cleared", 32'(countA), 1);
    laptopA = 1'b1;
    tick();
    laptopA = 1'b0;
    checkOutput("rdy_on_done_dropped", 32'(dropA), 1);
    checkOutput("rdy_on_done_idle", 32'(busyA), 0);
    tick();
    checkOutput("rdy_on_done_nostart", 32'(busyA), 0);

    // Asynchronous reset in the middle of a scan
    busA.win_ready = 1'b1;
    laptopA = 1'b1;
    tick();
    laptopA = 1'b0;
    waitValidA("midreset_start");
    tick();
    checkOutput("midreset_scanning", 32'(busA.win_valid), 1);
    #1 reset_n = 1'b0;
    #1 checkResetA("midreset");
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("midreset_no_done", 32'(doneA), 0);
    end
    reset_n = 1'b1;
    tick();
    checkOutput("after_reset_idle", 32'(busyA), 0);
    laptopA = 1'b1;
    tick();
    laptopA = 1'b0;
    for (int i = 1; i <= INT_WAIT; i++) tick();
    checkOutput("restart_valid", 32'(busA.win_valid), 1);
    checkWin("restart_idx", busA.img_index, busA.row_index, busA.col_index, 0, 0, 0);

    // Single 29x27 level
    busB.win_ready = 1'b1;
    laptopB = 1'b1;
    tick();
    laptopB = 1'b0;
    for (int i = 1; i <= INT_WAIT; i++) tick();
    for (int k = 0; k < NB; k++) begin
      checkOutput("b_valid", 32'(busB.win_valid), 1);
      checkWin("b_seq", busB.img_index, busB.row_index, busB.col_index,
               expB[k][0], expB[k][1], expB[k][2]);
      tick();
    end
    checkOutput("b_drain_valid", 32'(busB.win_valid), 0);
    checkOutput("b_drain_img", 32'(busB.img_index), 15);
    for (int i = 0; i < DRAIN_CYCLES + 4 && !doneB; i++) tick();
    checkOutput("b_done_seen", 32'(doneB), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vj_scan_scheduler.md
Name: vj_scan_scheduler

Overview:
Sequencing controller for the Viola-Jones detection datapath. After each new frame it waits for the pyramid integral images to settle. It then walks the scanning window over every pyramid level in raster order, presenting level, row and column indices to the window-select / std-dev / vj_pipeline datapath under a valid/ready handshake. It waits for the pipeline to drain, then reports frame completion and a per-frame face count.

Parameters:
LEVELS, 9, number of pyramid levels (1..15)
WINDOW_SIZE, 24, scanning window edge in pixels
WIDTHS, `PYRAMID_WIDTHS, packed [LEVELS-1:0][31:0] level widths, index 0 = full-size level
HEIGHTS, `PYRAMID_HEIGHTS, packed [LEVELS-1:0][31:0] level heights
INT_WAIT, 10, settle cycles after frame capture before the first window
DRAIN_CYCLES, 8, cycles after the last accepted window until results are final (pipeline depth)

Ports:
clock  in  1  system clock
reset_n  in  1  asynchronous active-low reset
laptop_img_rdy  in  1  single-cycle pulse: new frame captured into level 0
win_ready  in  1  datapath accepts the current window this cycle
face_in_valid  in  1  pulse from vj_pipeline: one face detected
img_index  out  4  current pyramid level; 4'd15 when not scanning
row_index  out  32  window top row within level
col_index  out  32  window left column within level
win_valid  out  1  indices valid, window offered to datapath
busy  out  1  frame in progress (SETTLE, SCAN or DRAIN)
frame_done  out  1  single-cycle pulse: frame fully processed
face_count  out  16  faces in current/last frame, saturating
img_dropped  out  1  single-cycle pulse: laptop_img_rdy ignored while busy

Behaviour:
- Reset (async, reset_n low): state IDLE; img_index=15; row_index=col_index=0; win_valid=0; busy=0; frame_done=0; face_count=0; img_dropped=0. All outputs are registered.
- Definitions: MAXC(l)=WIDTHS[l]-WINDOW_SIZE-1; MAXR(l)=HEIGHTS[l]-WINDOW_SIZE-1. Every level must satisfy MAXC, MAXR >= 0.
- IDLE:
  - laptop_img_rdy -> SETTLE; settle counter=1; face_count cleared to 0; busy=1 next cycle.
- SETTLE:
  - Counter increments each cycle.
  - When counter==INT_WAIT -> SCAN, with img_index=0, row_index=0, col_index=0, win_valid=1.
  - First window is offered INT_WAIT+1 cycles after the laptop_img_rdy edge.
- SCAN:
  - win_valid=1. Indices are held stable while win_ready=0; no advance and no skip.
  - On win_valid&&win_ready, advance:
    - col<MAXC: col+1.
    - Else if row<MAXR: col=0, row+1.
    - Else if img<LEVELS-1: img+1, row=col=0.
    - Else (last window of last level): -> DRAIN; win_valid=0; img_index=15; row=col=0; drain counter=1.
- DRAIN:
  - Counter increments each cycle.
  - When counter==DRAIN_CYCLES: frame_done=1 for exactly that cycle; -> IDLE; busy=0 in the same cycle frame_done deasserts.
- face_in_valid:
  - Counted in SETTLE, SCAN and DRAIN, including the frame_done cycle. Ignored in IDLE.
  - face_count=min(face_count+1, 16'hFFFF) on the next edge.
  - Value holds after frame_done until the next frame start.
- laptop_img_rdy while busy: ignored; no state change; img_dropped pulses the following cycle.
- laptop_img_rdy in the same cycle as frame_done: treated as busy, so dropped.
- Total windows per frame = sum over levels of (MAXC+1)*(MAXR+1), each accepted exactly once.
- Mid-frame reset_n: immediate return to reset values; no frame_done.

Optional Feature:
SCAN_STRIDE2_EN
- Defined: row and column steps are 2.
  - Column advances while col+2<=MAXC, otherwise wraps to 0 and steps the row.
  - Row advances while row+2<=MAXR, otherwise steps the level.
  - Visited positions are the even values <= MAXC/MAXR. Window count per level = (MAXC/2+1)*(MAXR/2+1), integer division.
- Undefined: stride 1 as above. All other behaviour is identical.

Test Plan:
1. Reset, then LEVELS=2, WIDTHS/HEIGHTS={25,26} (level0=26x26, level1=25x25), win_ready=1, pulse laptop_img_rdy -> first win_valid INT_WAIT+1 cycles later. Sequence (img,row,col) = (0,0,0),(0,0,1),(0,1,0),(0,1,1),(1,0,0); then win_valid=0, img_index=15; frame_done DRAIN_CYCLES cycles after the last accept.
2. Same setup, win_ready toggled 1,0,0,1 -> indices hold during the 0 cycles; exactly 5 windows accepted; no duplicates and no skips.
3. Three face_in_valid pulses during SCAN, one in the frame_done cycle -> face_count=4 after frame_done. Next laptop_img_rdy clears it to 0.
4. laptop_img_rdy during SCAN -> img_dropped single pulse; scan sequence unchanged; face_count not cleared.
5. Drive reset_n low mid-SCAN -> all outputs at reset values immediately; no frame_done; a new laptop_img_rdy restarts from (0,0,0).
6. SCAN_STRIDE2_EN, level0 29x27 (MAXC=4, MAXR=2), LEVELS=1 -> windows (0,0,0),(0,0,2),(0,0,4),(0,2,0),(0,2,2),(0,2,4); then DRAIN.
